// File: rtl/multicycle_control_if.sv
// Control-unit bus: instruction/flag inputs, datapath enables and status.
// Optional field: instr_count exists only when CTRL_PERF_EN is defined.
interface multicycle_control_if #(
    parameter int unsigned OP_W  = 3,
    parameter int unsigned CNT_W = 16
);
    logic [OP_W-1:0]  op;
    logic             zero;
    logic             mem_ready;
    logic             sigIRWrite;
    logic             sigPCWrite;
    logic [1:0]       sigPCSrc;
    logic             sigMemRead;
    logic             sigMemWrite;
    logic             sigMemtoReg;
    logic [1:0]       sigALUOp;
    logic             sigALUSrc;
    logic             sigRegWrite;
    logic             sigRegDst;
    logic [2:0]       state_o;
    logic             halted;
    logic             fault;
`ifdef CTRL_PERF_EN
    logic [CNT_W-1:0] instr_count;
`endif

    // Control unit side
    modport master (
`ifdef CTRL_PERF_EN
        output instr_count,
`endif
        input  op, zero, mem_ready,
        output sigIRWrite, sigPCWrite, sigPCSrc, sigMemRead, sigMemWrite,
        output sigMemtoReg, sigALUOp, sigALUSrc, sigRegWrite, sigRegDst,
        output state_o, halted, fault
    );

    // Datapath / memory side
    modport slave (
`ifdef CTRL_PERF_EN
        input  instr_count,
`endif
        output op, zero, mem_ready,
        input  sigIRWrite, sigPCWrite, sigPCSrc, sigMemRead, sigMemWrite,
        input  sigMemtoReg, sigALUOp, sigALUSrc, sigRegWrite, sigRegDst,
        input  state_o, halted, fault
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with memory
// handshake, wait-timeout FAULT and absorbing HALT.
// Optional feature macro: CTRL_PERF_EN (retired-instruction counter).
module multicycle_control #(
    parameter int unsigned OP_W        = 3,
    parameter int unsigned WAIT_W      = 4,
    parameter int unsigned MEM_TIMEOUT = 12,
    parameter int unsigned CNT_W       = 16
) (
    input logic                  clk,
    input logic                  reset,
    multicycle_control_if.master bus
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5,
        FAULT  = 3'd6
    } stateT;

    localparam logic [2:0] OpAluR   = 3'd0;
    localparam logic [2:0] OpLoad   = 3'd1;
    localparam logic [2:0] OpStore  = 3'd2;
    localparam logic [2:0] OpBranch = 3'd3;
    localparam logic [2:0] OpAluI   = 3'd4;
    localparam logic [2:0] OpJump   = 3'd5;
    localparam logic [2:0] OpNop    = 3'd6;
    localparam logic [2:0] OpHalt   = 3'd7;

    localparam logic [WAIT_W-1:0] TimeoutCnt = WAIT_W'(MEM_TIMEOUT);

    stateT             state, stateNext;
    logic [2:0]        opQ;
    logic [WAIT_W-1:0] waitCnt, waitNext;
    logic              retire;
    logic              irWrite, pcWrite, memRead, memWrite, memtoReg;
    logic              aluSrc, regWrite, regDst;
    logic [1:0]        pcSrc, aluOp;

    // State, latched opcode and memory-wait counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            opQ     <= 3'd0;
            waitCnt <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitNext;
            if (state == DECODE) begin
                opQ <= bus.op[2:0];
            end
        end
    end

    // Next state, wait-count update and datapath enables
    always_comb begin
        stateNext = state;
        waitNext  = '0;
        retire    = 1'b0;
        irWrite   = 1'b0;
        pcWrite   = 1'b0;
        pcSrc     = 2'b00;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        memtoReg  = 1'b0;
        aluOp     = 2'b00;
        aluSrc    = 1'b0;
        regWrite  = 1'b0;
        regDst    = 1'b0;
        case (state)
            FETCH: begin
                memRead = 1'b1;
                if (bus.mem_ready) begin
                    irWrite   = 1'b1;
                    pcWrite   = 1'b1;
                    stateNext = DECODE;
                end else if (waitCnt == TimeoutCnt) begin
                    stateNext = FAULT;
                end else begin
                    waitNext = waitCnt + WAIT_W'(1);
                end
            end
            DECODE: begin
                case (bus.op[2:0])
                    OpHalt:  stateNext = HALT;
                    OpNop: begin
                        stateNext = FETCH;
                        retire    = 1'b1;
                    end
                    default: stateNext = EXEC;
                endcase
            end
            EXEC: begin
                case (opQ)
                    OpAluR: begin
                        aluOp     = 2'b10;
                        stateNext = WB;
                    end
                    OpAluI: begin
                        aluOp     = 2'b10;
                        aluSrc    = 1'b1;
                        stateNext = WB;
                    end
                    OpLoad, OpStore: begin
                        aluSrc    = 1'b1;
                        stateNext = MEM;
                    end
                    OpBranch: begin
                        aluOp     = 2'b01;
                        pcSrc     = 2'b01;
                        pcWrite   = bus.zero;
                        stateNext = FETCH;
                        retire    = 1'b1;
                    end
                    OpJump: begin
                        pcSrc     = 2'b10;
                        pcWrite   = 1'b1;
                        stateNext = FETCH;
                        retire    = 1'b1;
                    end
                    default: stateNext = FAULT;
                endcase
            end
            MEM: begin
                memRead  = (opQ == OpLoad);
                memWrite = (opQ == OpStore);
                if (bus.mem_ready) begin
                    if (opQ == OpLoad) begin
                        stateNext = WB;
                    end else begin
                        stateNext = FETCH;
                        retire    = 1'b1;
                    end
                end else if (waitCnt == TimeoutCnt) begin
                    stateNext = FAULT;
                end else begin
                    waitNext = waitCnt + WAIT_W'(1);
                end
            end
            WB: begin
                regWrite  = 1'b1;
                memtoReg  = (opQ == OpLoad);
                regDst    = (opQ == OpAluR);
                stateNext = FETCH;
                retire    = 1'b1;
            end
            HALT:    stateNext = HALT;
            FAULT:   stateNext = FAULT;
            default: stateNext = FAULT;
        endcase
    end

    // Outputs are held at zero while reset is asserted
    assign bus.sigIRWrite  = irWrite  & ~reset;
    assign bus.sigPCWrite  = pcWrite  & ~reset;
    assign bus.sigPCSrc    = reset ? 2'b00 : pcSrc;
    assign bus.sigMemRead  = memRead  & ~reset;
    assign bus.sigMemWrite = memWrite & ~reset;
    assign bus.sigMemtoReg = memtoReg & ~reset;
    assign bus.sigALUOp    = reset ? 2'b00 : aluOp;
    assign bus.sigALUSrc   = aluSrc   & ~reset;
    assign bus.sigRegWrite = regWrite & ~reset;
    assign bus.sigRegDst   = regDst   & ~reset;
    assign bus.state_o     = reset ? 3'd0 : state;
    assign bus.halted      = (state == HALT)  & ~reset;
    assign bus.fault       = (state == FAULT) & ~reset;

`ifdef CTRL_PERF_EN
    logic [CNT_W-1:0] instrCount;

    // Retired-instruction counter; retire never fires in HALT or FAULT
    always_ff @(posedge clk) begin
        if (reset) begin
            instrCount <= '0;
        end else if (retire) begin
            instrCount <= instrCount + CNT_W'(1);
        end
    end

    assign bus.instr_count = reset ? '0 : instrCount;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed literal checks plus randomized
// stimulus compared every cycle against a path-table reference model.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic reset;

    multicycle_control_if #(.OP_W(3), .CNT_W(16)) busIf ();

    multicycle_control #(
        .OP_W(3), .WAIT_W(4), .MEM_TIMEOUT(12), .CNT_W(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (busIf)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each instruction is a list of stages after DECODE
    int mState = 0;
    int mOp    = 0;
    int mWait  = 0;
    int mCount = 0;
    int path[$];

    task automatic finishStage();
        if (path.size() == 0) begin
            mState = 0;
            mCount++;
        end else begin
            mState = path.pop_front();
        end
        mWait = 0;
    endtask

    task automatic waitOrFault();
        if (mWait == 12) mState = 6;
        else mWait++;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                mState = 0; mOp = 0; mWait = 0; mCount = 0;
                path.delete();
            end else begin
                case (mState)
                    0: if (busIf.mem_ready) begin mState = 1; mWait = 0; end
                       else waitOrFault();
                    1: begin
                        mOp = int'(busIf.op);
                        path.delete();
                        if (mOp == 7) begin
                            mState = 5;
                        end else begin
                            case (mOp)
                                0, 4: begin path.push_back(2); path.push_back(4); end
                                1: begin path.push_back(2); path.push_back(3); path.push_back(4); end
                                2: begin path.push_back(2); path.push_back(3); end
                                3, 5: path.push_back(2);
                                default: ;
                            endcase
                            finishStage();
                        end
                    end
                    2, 4: finishStage();
                    3: if (busIf.mem_ready) finishStage();
                       else waitOrFault();
                    default: ;
                endcase
            end
        end
    end

    // Expected enables {IRWrite,PCWrite,PCSrc,MemRead,MemWrite,MemtoReg,ALUOp,ALUSrc,RegWrite,RegDst}
    function automatic logic [11:0] expOut(int st, int mop, logic z, logic rdy);
        logic irw, pcw, mr, mw, m2r, als, rw, rd;
        logic [1:0] pcs, alo;
        irw = 0; pcw = 0; mr = 0; mw = 0; m2r = 0; als = 0; rw = 0; rd = 0;
        pcs = 2'd0; alo = 2'd0;
        case (st)
            0: begin mr = 1; irw = rdy; pcw = rdy; end
            2: case (mop)
                0: alo = 2'd2;
                4: begin alo = 2'd2; als = 1; end
                1, 2: als = 1;
                3: begin alo = 2'd1; pcs = 2'd1; pcw = z; end
                5: begin pcs = 2'd2; pcw = 1; end
                default: ;
            endcase
            3: begin mr = (mop == 1); mw = (mop == 2); end
            4: begin rw = 1; m2r = (mop == 1); rd = (mop == 0); end
            default: ;
        endcase
        return {irw, pcw, pcs, mr, mw, m2r, alo, als, rw, rd};
    endfunction

    function automatic logic [11:0] dutOut();
        return {busIf.sigIRWrite, busIf.sigPCWrite, busIf.sigPCSrc, busIf.sigMemRead,
                busIf.sigMemWrite, busIf.sigMemtoReg, busIf.sigALUOp, busIf.sigALUSrc,
                busIf.sigRegWrite, busIf.sigRegDst};
    endfunction

    // Per-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("m_enables_rst", int'(dutOut()), 0);
                chk("m_state_rst", int'(busIf.state_o), 0);
                chk("m_status_rst", int'({busIf.halted, busIf.fault}), 0);
            end else begin
                chk("m_enables", int'(dutOut()),
                    int'(expOut(mState, mOp, busIf.zero, busIf.mem_ready)));
                chk("m_state", int'(busIf.state_o), mState);
                chk("m_halted", int'(busIf.halted), int'(mState == 5));
                chk("m_fault", int'(busIf.fault), int'(mState == 6));
`ifdef CTRL_PERF_EN
                chk("m_instr_count", int'(busIf.instr_count), mCount % 65536);
`endif
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic startOp(input logic [2:0] o);
        reset = 1'b1; busIf.mem_ready = 1'b0;
        cyc(); cyc();
        reset = 1'b0; busIf.mem_ready = 1'b1; busIf.op = o;
    endtask

    int readyPct[4] = '{100, 70, 30, 5};

    initial begin
        reset = 1'b1; busIf.mem_ready = 1'b0; busIf.op = 3'd0; busIf.zero = 1'b0;
        cyc(); cyc();
        #1;
        chk("reset_state", int'(busIf.state_o), 0);
        chk("reset_memread", int'(busIf.sigMemRead), 0);

        // ALU-R with zero-wait memory
        reset = 1'b0; busIf.mem_ready = 1'b1; busIf.op = 3'd0;
        #1;
        chk("fetch_state", int'(busIf.state_o), 0);
        chk("fetch_enables", int'({busIf.sigMemRead, busIf.sigIRWrite, busIf.sigPCWrite}), 7);
        cyc(); #1; chk("alur_decode", int'(busIf.state_o), 1);
        cyc(); #1; chk("alur_exec", int'(busIf.state_o), 2);
        chk("alur_aluop", int'(busIf.sigALUOp), 2);
        cyc(); #1; chk("alur_wb", int'(busIf.state_o), 4);
        chk("alur_wb_en", int'({busIf.sigRegWrite, busIf.sigRegDst}), 3);
        cyc(); #1; chk("alur_back", int'(busIf.state_o), 0);
`ifdef CTRL_PERF_EN
        chk("alur_count", int'(busIf.instr_count), 1);
`endif

        // LOAD with three stalled MEM cycles
        busIf.op = 3'd1;
        cyc(); #1; chk("load_decode", int'(busIf.state_o), 1);
        cyc(); #1; chk("load_exec_alusrc", int'({busIf.sigALUOp, busIf.sigALUSrc}), 1);
        busIf.mem_ready = 1'b0;
        cyc(); #1;
        for (int i = 0; i < 3; i++) begin
            chk("load_mem_hold", int'({busIf.state_o, busIf.sigMemRead}), 7);
            cyc(); #1;
        end
        busIf.mem_ready = 1'b1; #1;
        chk("load_mem_last", int'({busIf.state_o, busIf.sigMemRead}), 7);
        cyc(); #1;
        chk("load_wb", int'({busIf.state_o, busIf.sigMemtoReg, busIf.sigRegWrite, busIf.sigRegDst}), 38);
        cyc(); #1; chk("load_back", int'(busIf.state_o), 0);

        // BRANCH taken then not taken
        busIf.op = 3'd3; busIf.zero = 1'b1;
        cyc(); cyc(); #1;
        chk("br_taken", int'({busIf.sigPCWrite, busIf.sigPCSrc, busIf.sigALUOp}), 5'b10101);
        cyc(); #1; chk("br_taken_back", int'(busIf.state_o), 0);
        busIf.zero = 1'b0;
        cyc(); cyc(); #1;
        chk("br_not_taken", int'({busIf.sigPCWrite, busIf.sigPCSrc}), 1);
        cyc(); #1; chk("br_nt_back", int'(busIf.state_o), 0);

        // Randomized traffic with varying memory readiness and sporadic reset
        for (int blk = 0; blk < 12; blk++) begin
            int pct;
            pct = readyPct[blk % 4];
            for (int c = 0; c < 200; c++) begin
                cyc();
                reset = ($urandom_range(0, 63) == 0);
                busIf.mem_ready = ($urandom_range(0, 99) < pct);
                busIf.op = 3'($urandom);
                busIf.zero = 1'($urandom);
            end
        end

        // STORE with memory never ready times out into FAULT
        startOp(3'd2);
        cyc(); cyc(); #1;
        busIf.mem_ready = 1'b0;
        cyc(); #1;
        for (int i = 0; i < 13; i++) begin
            chk("store_wait", int'({busIf.state_o, busIf.sigMemWrite, busIf.fault}), 3'd3 * 4 + 2);
            cyc(); #1;
        end
        chk("store_fault", int'({busIf.state_o, busIf.sigMemWrite, busIf.fault}), 6 * 4 + 1);
        busIf.mem_ready = 1'b1;
        cyc(); cyc(); #1;
        chk("fault_sticky", int'(busIf.fault), 1);

        // HALT is absorbing until reset
        startOp(3'd7);
        cyc(); cyc(); #1;
        chk("halt_state", int'({busIf.state_o, busIf.halted}), 11);
        chk("halt_enables", int'(dutOut()), 0);
        cyc(); cyc(); #1;
        chk("halt_sticky", int'(busIf.halted), 1);
        reset = 1'b1;
        cyc(); #1;
        reset = 1'b0; #1;
        chk("halt_reset", int'({busIf.state_o, busIf.halted}), 0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
